pipe_hazard_ctrl: RTL and testbench

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

---
 rtl/pipe_hazard_ctrl_pkg.sv | 66 ++++++
 rtl/pipe_hazard_ctrl_fwd.sv | 65 ++++++
 rtl/pipe_hazard_ctrl.sv | 173 +++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: opcodes, FSM states,
// forwarding-select encodings and the per-opcode producer/consumer tables.
package pipe_hazard_ctrl_pkg;

    localparam int OP_BITS = 4;

    localparam logic [3:0] OP_NOP     = 4'h0;
    localparam logic [3:0] OP_ADD     = 4'h1;
    localparam logic [3:0] OP_SUB     = 4'h2;
    localparam logic [3:0] OP_NAND    = 4'h3;
    localparam logic [3:0] OP_SHL     = 4'h4;
    localparam logic [3:0] OP_SHR     = 4'h5;
    localparam logic [3:0] OP_TST     = 4'h6;
    localparam logic [3:0] OP_MOVI    = 4'h7;
    localparam logic [3:0] OP_MOV     = 4'h8;
    localparam logic [3:0] OP_BEQ     = 4'h9;
    localparam logic [3:0] OP_BNE     = 4'hA;
    localparam logic [3:0] OP_JMP     = 4'hB;
    localparam logic [3:0] OP_OUT     = 4'hC;
    localparam logic [3:0] OP_LOAD    = 4'hD;
    localparam logic [3:0] OP_STORE   = 4'hE;
    localparam logic [3:0] OP_LOADIMM = 4'hF;

    typedef enum logic [1:0] {
        ST_RUN   = 2'b00,
        ST_STALL = 2'b01,
        ST_FLUSH = 2'b10,
        ST_BAD   = 2'b11
    } state_t;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_EX  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    function automatic logic is_writer(input logic [OP_BITS-1:0] op);
        logic w;
        case (op)
            OP_ADD, OP_SUB, OP_NAND, OP_SHL, OP_SHR,
            OP_MOVI, OP_MOV, OP_LOAD, OP_LOADIMM:      w = 1'b1;
            OP_NOP, OP_TST, OP_BEQ, OP_BNE, OP_JMP,
            OP_OUT, OP_STORE:                          w = 1'b0;
            default:                                   w = 1'b0;
        endcase
        return w;
    endfunction

    function automatic logic reads_ra(input logic [OP_BITS-1:0] op);
        logic r;
        case (op)
            OP_ADD, OP_SUB, OP_NAND, OP_STORE,
            OP_SHL, OP_SHR, OP_TST:                    r = 1'b1;
            default:                                   r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic reads_rb(input logic [OP_BITS-1:0] op);
        logic r;
        case (op)
            OP_ADD, OP_SUB, OP_NAND, OP_STORE, OP_MOV: r = 1'b1;
            default:                                   r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_fwd.sv
// Combinational operand-forwarding selects for the instruction in decode,
// choosing between register file, EX-stage result and MEM/WB data.
module hazard_fwd_unit
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int OP_W = 4
) (
    input  logic [OP_W-1:0] i_dec_op,
    input  logic [1:0]      i_dec_ra,
    input  logic [1:0]      i_dec_rb,
    input  logic            i_dec_valid,
    input  logic [OP_W-1:0] i_ex_op,
    input  logic [1:0]      i_ex_dst,
    input  logic            i_ex_valid,
    input  logic [OP_W-1:0] i_mem_op,
    input  logic [1:0]      i_mem_dst,
    input  logic            i_mem_valid,
    output logic [1:0]      o_fwd_a_sel,
    output logic [1:0]      o_fwd_b_sel
);

    logic w_ex_ok;
    logic w_mem_ok;

    // A load in EX has no data yet; it can only be forwarded once it reaches MEM.
    assign w_ex_ok  = i_ex_valid && is_writer(i_ex_op) && (i_ex_op != OP_LOAD);
    assign w_mem_ok = i_mem_valid && is_writer(i_mem_op);

    function automatic logic [1:0] pick_src(
        input logic       used,
        input logic [1:0] src,
        input logic       ex_ok,
        input logic [1:0] ex_dst,
        input logic       mem_ok,
        input logic [1:0] mem_dst
    );
        logic [1:0] sel;
        if (!used) begin
            sel = FWD_RF;
        end else if (ex_ok && (ex_dst == src)) begin
            sel = FWD_EX;
        end else if (mem_ok && (mem_dst == src)) begin
            sel = FWD_MEM;
        end else begin
            sel = FWD_RF;
        end
        return sel;
    endfunction

    // Per-operand source selection, youngest producer first.
    always_comb begin
        o_fwd_a_sel = FWD_RF;
        o_fwd_b_sel = FWD_RF;
        if (i_dec_valid) begin
            o_fwd_a_sel = pick_src(reads_ra(i_dec_op), i_dec_ra, w_ex_ok, i_ex_dst,
                                   w_mem_ok, i_mem_dst);
            o_fwd_b_sel = pick_src(reads_rb(i_dec_op), i_dec_rb, w_ex_ok, i_ex_dst,
                                   w_mem_ok, i_mem_dst);
        end else begin
            o_fwd_a_sel = FWD_RF;
            o_fwd_b_sel = FWD_RF;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard controller for a short in-order pipeline: load-use stall, taken-branch
// flush, and operand forwarding selects for the instruction in decode.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2,
    parameter int OP_W         = 4
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [7:0] i_dec_ins,
    input  logic       i_dec_valid,
    input  logic       i_br_taken,
    output logic       o_pc_we,
    output logic       o_ifid_we,
    output logic       o_ifid_flush,
    output logic       o_idex_bubble,
    output logic [1:0] o_fwd_a_sel,
    output logic [1:0] o_fwd_b_sel,
    output logic [1:0] o_state
);

    localparam logic [1:0] FLUSH_LOAD = 2'(FLUSH_CYCLES - 1);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [1:0]      r_flush_cnt;
    logic [1:0]      w_flush_cnt_nxt;

    logic [7:0]      r_ex_ins;
    logic [7:0]      r_mem_ins;
    logic [7:0]      r_wb_ins;
    logic            r_ex_vld;
    logic            r_mem_vld;
    logic            r_wb_vld;

    logic [OP_W-1:0] w_dec_op;
    logic [OP_W-1:0] w_ex_op;
    logic [OP_W-1:0] w_mem_op;
    logic [1:0]      w_dec_ra;
    logic [1:0]      w_dec_rb;
    logic [1:0]      w_ex_dst;
    logic [1:0]      w_mem_dst;
    logic            w_load_use;
    logic [1:0]      w_fwd_a;
    logic [1:0]      w_fwd_b;
    logic            w_unused_bits;

    assign w_dec_op  = i_dec_ins[7 -: OP_W];
    assign w_dec_ra  = i_dec_ins[3:2];
    assign w_dec_rb  = i_dec_ins[1:0];
    assign w_ex_op   = r_ex_ins[7 -: OP_W];
    assign w_ex_dst  = r_ex_ins[3:2];
    assign w_mem_op  = r_mem_ins[7 -: OP_W];
    assign w_mem_dst = r_mem_ins[3:2];

    // WB is tracked for completeness of the pipeline image but feeds no decision.
    assign w_unused_bits = ^{r_ex_ins[1:0], r_mem_ins[1:0], r_wb_ins, r_wb_vld};

    assign w_load_use = (r_state == ST_RUN) && r_ex_vld && (w_ex_op == OP_LOAD)
                     && i_dec_valid
                     && ((reads_ra(w_dec_op) && (w_dec_ra == w_ex_dst))
                      || (reads_rb(w_dec_op) && (w_dec_rb == w_ex_dst)));

    hazard_fwd_unit #(
        .OP_W (OP_W)
    ) u_fwd (
        .i_dec_op    (w_dec_op),
        .i_dec_ra    (w_dec_ra),
        .i_dec_rb    (w_dec_rb),
        .i_dec_valid (i_dec_valid),
        .i_ex_op     (w_ex_op),
        .i_ex_dst    (w_ex_dst),
        .i_ex_valid  (r_ex_vld),
        .i_mem_op    (w_mem_op),
        .i_mem_dst   (w_mem_dst),
        .i_mem_valid (r_mem_vld),
        .o_fwd_a_sel (w_fwd_a),
        .o_fwd_b_sel (w_fwd_b)
    );

    assign o_fwd_a_sel = i_rst_n ? w_fwd_a : FWD_RF;
    assign o_fwd_b_sel = i_rst_n ? w_fwd_b : FWD_RF;
    assign o_state     = r_state;

    // Next-state and pipeline-control decode; a taken branch overrides any stall.
    always_comb begin
        w_state_nxt     = r_state;
        w_flush_cnt_nxt = r_flush_cnt;
        o_pc_we         = 1'b1;
        o_ifid_we       = 1'b1;
        o_ifid_flush    = 1'b0;
        o_idex_bubble   = 1'b0;
        if (!i_rst_n) begin
            o_pc_we         = 1'b0;
            o_ifid_we       = 1'b0;
            o_ifid_flush    = 1'b1;
            o_idex_bubble   = 1'b1;
            w_state_nxt     = ST_RUN;
            w_flush_cnt_nxt = 2'd0;
        end else if (i_br_taken) begin
            o_ifid_flush    = 1'b1;
            o_idex_bubble   = 1'b1;
            w_state_nxt     = ST_FLUSH;
            w_flush_cnt_nxt = FLUSH_LOAD;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (w_load_use) begin
                        o_pc_we       = 1'b0;
                        o_ifid_we     = 1'b0;
                        o_idex_bubble = 1'b1;
                        w_state_nxt   = ST_STALL;
                    end else begin
                        w_state_nxt   = ST_RUN;
                    end
                end
                ST_STALL: begin
                    w_state_nxt = ST_RUN;
                end
                ST_FLUSH: begin
                    if (r_flush_cnt != 2'd0) begin
                        o_ifid_flush    = 1'b1;
                        o_idex_bubble   = 1'b1;
                        w_flush_cnt_nxt = r_flush_cnt - 2'd1;
                        w_state_nxt     = ST_FLUSH;
                    end else begin
                        w_state_nxt     = ST_RUN;
                    end
                end
                ST_BAD: begin
                    w_state_nxt     = ST_RUN;
                    w_flush_cnt_nxt = 2'd0;
                end
                default: begin
                    w_state_nxt     = ST_RUN;
                    w_flush_cnt_nxt = 2'd0;
                end
            endcase
        end
    end

    // FSM state and flush counter.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= ST_RUN;
            r_flush_cnt <= 2'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_flush_cnt <= w_flush_cnt_nxt;
        end
    end

    // Shadow of the EX/MEM/WB instructions; a bubble enters EX as an invalid NOP.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ex_ins  <= 8'h00;
            r_ex_vld  <= 1'b0;
            r_mem_ins <= 8'h00;
            r_mem_vld <= 1'b0;
            r_wb_ins  <= 8'h00;
            r_wb_vld  <= 1'b0;
        end else begin
            r_ex_ins  <= o_idex_bubble ? 8'h00 : i_dec_ins;
            r_ex_vld  <= o_idex_bubble ? 1'b0 : i_dec_valid;
            r_mem_ins <= r_ex_ins;
            r_mem_vld <= r_ex_vld;
            r_wb_ins  <= r_mem_ins;
            r_wb_vld  <= r_mem_vld;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios plus randomized
// traffic compared each cycle against a behavioural pipeline model.
module tb_pipe_hazard_ctrl;

    localparam int FC = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] dec_ins = 8'h00;
    logic       dec_valid = 1'b0;
    logic       br_taken = 1'b0;
    logic       pc_we, ifid_we, ifid_flush, idex_bubble;
    logic [1:0] fwd_a_sel, fwd_b_sel, state;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.FLUSH_CYCLES(FC), .OP_W(4)) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_dec_ins     (dec_ins),
        .i_dec_valid   (dec_valid),
        .i_br_taken    (br_taken),
        .o_pc_we       (pc_we),
        .o_ifid_we     (ifid_we),
        .o_ifid_flush  (ifid_flush),
        .o_idex_bubble (idex_bubble),
        .o_fwd_a_sel   (fwd_a_sel),
        .o_fwd_b_sel   (fwd_b_sel),
        .o_state       (state)
    );

    wire [9:0] got = {pc_we, ifid_we, ifid_flush, idex_bubble, fwd_a_sel, fwd_b_sel, state};
    localparam logic [9:0] RST_VEC = 10'b0011_00_00_00;

    // Behavioural model: stage contents plus "stalling" / "flushing, n bubbles left".
    bit         m_stall, m_flush, n_stall, n_flush;
    int         m_left, n_left;
    logic [7:0] m_ex_ins, m_mem_ins;
    bit         m_ex_v, m_mem_v;
    logic [9:0] e_vec;
    logic       e_bub;

    function automatic bit writes(input logic [3:0] op);
        return op inside {4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h7, 4'h8, 4'hD, 4'hF};
    endfunction
    function automatic bit rd_a(input logic [3:0] op);
        return op inside {4'h1, 4'h2, 4'h3, 4'hE, 4'h4, 4'h5, 4'h6};
    endfunction
    function automatic bit rd_b(input logic [3:0] op);
        return op inside {4'h1, 4'h2, 4'h3, 4'hE, 4'h8};
    endfunction

    function automatic logic [1:0] ref_sel(input bit used, input logic [1:0] r);
        if (!used || !dec_valid) return 2'b00;
        if (m_ex_v && writes(m_ex_ins[7:4]) && m_ex_ins[7:4] != 4'hD && m_ex_ins[3:2] == r)
            return 2'b01;
        if (m_mem_v && writes(m_mem_ins[7:4]) && m_mem_ins[3:2] == r) return 2'b10;
        return 2'b00;
    endfunction

    task automatic model_reset();
        m_stall = 0; m_flush = 0; m_left = 0;
        m_ex_v = 0; m_mem_v = 0; m_ex_ins = 8'h00; m_mem_ins = 8'h00;
    endtask

    task automatic model_eval();
        bit lu;
        logic pc, ifid, fl;
        logic [1:0] st;
        if (!rst_n) begin
            e_vec = RST_VEC; e_bub = 1'b1;
            n_stall = 0; n_flush = 0; n_left = 0;
        end else begin
            lu = !m_stall && !m_flush && m_ex_v && m_ex_ins[7:4] == 4'hD && dec_valid
              && ((rd_a(dec_ins[7:4]) && dec_ins[3:2] == m_ex_ins[3:2])
               || (rd_b(dec_ins[7:4]) && dec_ins[1:0] == m_ex_ins[3:2]));
            pc = 1'b1; ifid = 1'b1; fl = 1'b0; e_bub = 1'b0;
            st = m_stall ? 2'b01 : (m_flush ? 2'b10 : 2'b00);
            n_stall = 0; n_flush = m_flush; n_left = m_left;
            if (br_taken) begin
                fl = 1'b1; e_bub = 1'b1; n_flush = 1; n_left = FC - 1;
            end else if (m_flush) begin
                if (m_left > 0) begin fl = 1'b1; e_bub = 1'b1; n_left = m_left - 1; end
                else n_flush = 0;
            end else if (lu) begin
                pc = 1'b0; ifid = 1'b0; e_bub = 1'b1; n_stall = 1;
            end
            e_vec = {pc, ifid, fl, e_bub, ref_sel(rd_a(dec_ins[7:4]), dec_ins[3:2]),
                     ref_sel(rd_b(dec_ins[7:4]), dec_ins[1:0]), st};
        end
    endtask

    task automatic apply(input logic [7:0] ins, input logic v, input logic br);
        dec_ins = ins; dec_valid = v; br_taken = br;
        model_eval();
        #2;
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst_n) model_reset();
        else begin
            m_stall = n_stall; m_flush = n_flush; m_left = n_left;
            m_mem_ins = m_ex_ins; m_mem_v = m_ex_v;
            m_ex_ins = e_bub ? 8'h00 : dec_ins; m_ex_v = e_bub ? 1'b0 : dec_valid;
        end
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            apply(8'h00, 1'b0, 1'b0);
            checks++;
            if (got !== e_vec) begin errors++; $display("FAIL idle got %b exp %b", got, e_vec); end
            tick();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        apply(8'h16, 1'b1, 1'b0);
        checks++;
        if (got !== RST_VEC) begin errors++; $display("FAIL reset_outputs got %b exp %b", got, RST_VEC); end
        tick();
        tick();
        rst_n = 1'b1;
        idle(1);
    endtask

    task automatic test_load_use();
        idle(2);
        apply(8'hD4, 1'b1, 1'b0);
        checks++;
        if (got !== e_vec) begin errors++; $display("FAIL lu_load got %b exp %b", got, e_vec); end
        tick();
        apply(8'h16, 1'b1, 1'b0);
        checks++;
        if (got !== e_vec || pc_we !== 1'b0 || idex_bubble !== 1'b1 || ifid_we !== 1'b0) begin
            errors++; $display("FAIL lu_stall got %b exp %b", got, e_vec);
        end
        tick();
        apply(8'h16, 1'b1, 1'b0);
        checks++;
        if (got !== e_vec || fwd_a_sel !== 2'b10 || pc_we !== 1'b1 || idex_bubble !== 1'b0) begin
            errors++; $display("FAIL lu_issue got %b exp %b", got, e_vec);
        end
        tick();
        apply(8'h00, 1'b0, 1'b0);
        checks++;
        if (got !== e_vec || state !== 2'b00) begin
            errors++; $display("FAIL lu_back_to_run got %b exp %b", got, e_vec);
        end
        tick();
    endtask

    task automatic test_alu_fwd();
        idle(3);
        apply(8'h18, 1'b1, 1'b0);
        tick();
        apply(8'h22, 1'b1, 1'b0);
        checks++;
        if (got !== e_vec || fwd_b_sel !== 2'b01 || fwd_a_sel !== 2'b00 || pc_we !== 1'b1) begin
            errors++; $display("FAIL alu_fwd got %b exp %b", got, e_vec);
        end
        tick();
    endtask

    task automatic test_mem_fwd();
        idle(3);
        apply(8'h18, 1'b1, 1'b0);
        tick();
        apply(8'h30, 1'b1, 1'b0);
        tick();
        apply(8'h48, 1'b1, 1'b0);
        checks++;
        if (got !== e_vec || fwd_a_sel !== 2'b10 || fwd_b_sel !== 2'b00) begin
            errors++; $display("FAIL mem_fwd got %b exp %b", got, e_vec);
        end
        tick();
    endtask

    task automatic test_branch(input int pulses);
        int bubbles;
        idle(2);
        bubbles = 0;
        for (int c = 0; c < 6; c++) begin
            apply(8'($urandom), 1'b1, (c < pulses) ? 1'b1 : 1'b0);
            checks++;
            if (got !== e_vec) begin errors++; $display("FAIL branch_c%0d got %b exp %b", c, got, e_vec); end
            if (idex_bubble === 1'b1) bubbles++;
            tick();
        end
        checks++;
        if (bubbles != FC + pulses - 1 || state !== 2'b00) begin
            errors++; $display("FAIL branch_bubbles got %0d exp %0d state %b", bubbles, FC + pulses - 1, state);
        end
    endtask

    task automatic test_simultaneous();
        idle(2);
        apply(8'hD4, 1'b1, 1'b0);
        tick();
        apply(8'h16, 1'b1, 1'b1);
        checks++;
        if (got !== e_vec || pc_we !== 1'b1 || idex_bubble !== 1'b1 || ifid_flush !== 1'b1) begin
            errors++; $display("FAIL simul_branch got %b exp %b", got, e_vec);
        end
        tick();
        for (int c = 0; c < 4; c++) begin
            apply(8'h16, 1'b1, 1'b0);
            checks++;
            if (got !== e_vec || state === 2'b01 || (c == 0 && state !== 2'b10)) begin
                errors++; $display("FAIL simul_nostall_c%0d got %b exp %b", c, got, e_vec);
            end
            tick();
        end
    endtask

    task automatic test_reset_mid_stall();
        idle(2);
        apply(8'hD4, 1'b1, 1'b0);
        tick();
        apply(8'h16, 1'b1, 1'b0);
        tick();
        apply(8'h16, 1'b1, 1'b0);
        checks++;
        if (state !== 2'b01) begin errors++; $display("FAIL rst_stall_entry got %b exp 01", state); end
        rst_n = 1'b0;
        model_eval();
        #1;
        checks++;
        if (got !== RST_VEC) begin errors++; $display("FAIL rst_mid_stall got %b exp %b", got, RST_VEC); end
        tick();
        rst_n = 1'b1;
        apply(8'h16, 1'b1, 1'b0);
        checks++;
        if (got !== e_vec || state !== 2'b00 || fwd_a_sel !== 2'b00 || fwd_b_sel !== 2'b00) begin
            errors++; $display("FAIL rst_release got %b exp %b", got, e_vec);
        end
        tick();
    endtask

    task automatic test_random(input int n);
        logic [7:0] ins;
        for (int c = 0; c < n; c++) begin
            if ($urandom_range(0, 2) == 0) ins = {4'hD, 4'($urandom)};
            else ins = 8'($urandom);
            apply(ins, ($urandom_range(0, 3) != 0), ($urandom_range(0, 9) == 0));
            checks++;
            if (got !== e_vec) begin
                errors++;
                $display("FAIL random_c%0d ins %h got %b exp %b", c, ins, got, e_vec);
            end
            tick();
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_load_use();
        test_alu_fwd();
        test_mem_fwd();
        test_branch(1);
        test_branch(2);
        test_simultaneous();
        test_reset_mid_stall();
        test_random(600);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
